// File: rtl/display_mode_scheduler_pkg.sv
// Shared constants for the nixie display mode scheduler: mode codes, 6-bit tube
// character codes, blank and banner frames, FSM state encoding, timer sizing.
package display_mode_scheduler_pkg;

    // Mode codes as presented on mode_in
    localparam logic [1:0] MODE_FREE  = 2'b00;
    localparam logic [1:0] MODE_LEARN = 2'b01;
    localparam logic [1:0] MODE_PLAY  = 2'b10;
    localparam logic [1:0] MODE_UART  = 2'b11;

    // Tube character codes: digits 0-9 use 0-9, letters follow alphabetically from 10.
    // The glyph case (e.g. "r", "n", "t") is fixed by the tube segment map, not by the code.
    localparam logic [5:0] CHAR_A     = 6'd10;
    localparam logic [5:0] CHAR_E     = 6'd14;
    localparam logic [5:0] CHAR_F     = 6'd15;
    localparam logic [5:0] CHAR_L     = 6'd21;
    localparam logic [5:0] CHAR_N     = 6'd23;
    localparam logic [5:0] CHAR_P     = 6'd25;
    localparam logic [5:0] CHAR_R     = 6'd27;
    localparam logic [5:0] CHAR_T     = 6'd29;
    localparam logic [5:0] CHAR_U     = 6'd30;
    localparam logic [5:0] CHAR_Y     = 6'd34;
    localparam logic [5:0] CHAR_BLANK = 6'b111111;

    localparam logic [47:0] FRAME_BLANK = {8{CHAR_BLANK}};

    // Mode-name banners, left-justified ([47:42] is the leftmost tube)
    localparam logic [47:0] BANNER_FREE  = {CHAR_F, CHAR_R, CHAR_E, CHAR_E, {4{CHAR_BLANK}}};
    localparam logic [47:0] BANNER_LEARN = {CHAR_L, CHAR_E, CHAR_A, CHAR_R, CHAR_N,
                                            {3{CHAR_BLANK}}};
    localparam logic [47:0] BANNER_PLAY  = {CHAR_P, CHAR_L, CHAR_A, CHAR_Y, {4{CHAR_BLANK}}};
    localparam logic [47:0] BANNER_UART  = {CHAR_U, CHAR_A, CHAR_R, CHAR_T, {4{CHAR_BLANK}}};

    typedef enum logic [1:0] {
        StBanner = 2'b00,
        StLive   = 2'b01,
        StMsg    = 2'b10
    } state_e;

    function automatic logic [47:0] banner_frame(logic [1:0] mode);
        case (mode)
            MODE_LEARN: banner_frame = BANNER_LEARN;
            MODE_PLAY:  banner_frame = BANNER_PLAY;
            MODE_UART:  banner_frame = BANNER_UART;
            default:    banner_frame = BANNER_FREE;
        endcase
    endfunction

    // Timer width: at least base, and wide enough to hold (dwell - 1) for every dwell.
    function automatic int unsigned timer_width(int unsigned base, int unsigned dwell_a,
                                                int unsigned dwell_b, int unsigned dwell_c);
        int unsigned w;
        w = (base > 0) ? base : 1;
        if ($clog2(dwell_a) > w) w = $clog2(dwell_a);
        if ($clog2(dwell_b) > w) w = $clog2(dwell_b);
        if ($clog2(dwell_c) > w) w = $clog2(dwell_c);
        return w;
    endfunction

endpackage

// File: rtl/display_mode_scheduler_dwell_timer.sv
// Dwell timer: up-counter with synchronous clear/enable and a terminal-count flag.
module display_mode_scheduler_dwell_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [Width-1:0] i_term,
    output logic             o_tc
);

    logic [Width-1:0] r_count;

    // Clear wins over count so every state entry starts from zero.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + Width'(1);
        end
    end

    assign o_tc = (r_count == i_term);

endmodule

// File: rtl/display_mode_scheduler.sv
// Display mode scheduler: picks the frame sent to the 8-digit nixie driver.
// A mode change shows a timed name banner; a msg_req/msg_ack handshake overlays a
// one-shot message frame. Define DISPLAY_MSG_BLINK_EN to blink the message in MSG.
module display_mode_scheduler
    import display_mode_scheduler_pkg::*;
#(
    parameter int unsigned CNT_W         = 27,
    parameter int unsigned BANNER_CYCLES = 100_000_000,
    parameter int unsigned MSG_CYCLES    = 200_000_000,
    parameter int unsigned BLINK_CYCLES  = 25_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rest,
    input  logic [1:0]  mode_in,
    input  logic [47:0] free_frame,
    input  logic [47:0] learn_frame,
    input  logic [47:0] play_frame,
    input  logic        msg_req,
    input  logic [47:0] msg_frame,
    output logic        msg_ack,
    output logic [47:0] frame_out,
    output logic        frame_upd,
    output logic        busy
);

    // Never narrower than needed for the longest dwell, whatever CNT_W says.
    localparam int unsigned TimerW = timer_width(CNT_W, BANNER_CYCLES, MSG_CYCLES,
                                                 BLINK_CYCLES);
    localparam logic [TimerW-1:0] BannerTerm = TimerW'(BANNER_CYCLES - 1);
    localparam logic [TimerW-1:0] MsgTerm    = TimerW'(MSG_CYCLES - 1);

    state_e      r_fsm;
    state_e      w_fsm_d;
    logic [1:0]  r_mode;
    logic [1:0]  w_mode_d;
    logic [47:0] r_msg;
    logic [47:0] w_msg_d;
    logic [47:0] r_frame_out;
    logic [47:0] w_frame_d;
    logic        r_msg_ack;
    logic        w_ack_d;
    logic        r_frame_upd;
    logic        r_busy;

    logic        w_mode_chg;
    logic        w_dwell_clr;
    logic        w_dwell_tc;
    logic [TimerW-1:0] w_dwell_term;
    logic [47:0] w_live_frame;
    logic [47:0] w_msg_shown;

    assign w_mode_chg   = (mode_in != r_mode);
    assign w_dwell_term = (r_fsm == StBanner) ? BannerTerm : MsgTerm;
    // Held clear in LIVE and on every state entry (including banner restart).
    assign w_dwell_clr  = w_mode_chg || (w_fsm_d != r_fsm) || (r_fsm == StLive);

    display_mode_scheduler_dwell_timer #(
        .Width (TimerW)
    ) u_dwell (
        .i_clk  (sys_clk),
        .i_rst  (sys_rest),
        .i_clr  (w_dwell_clr),
        .i_en   (1'b1),
        .i_term (w_dwell_term),
        .o_tc   (w_dwell_tc)
    );

`ifdef DISPLAY_MSG_BLINK_EN
    localparam logic [TimerW-1:0] BlinkTerm = TimerW'(BLINK_CYCLES - 1);

    logic w_blink_tc;
    logic r_blink_vis;

    display_mode_scheduler_dwell_timer #(
        .Width (TimerW)
    ) u_blink (
        .i_clk  (sys_clk),
        .i_rst  (sys_rest),
        .i_clr  ((r_fsm != StMsg) || w_blink_tc),
        .i_en   (1'b1),
        .i_term (BlinkTerm),
        .o_tc   (w_blink_tc)
    );

    // Blink phase: visible on MSG entry, toggles every BLINK_CYCLES while in MSG.
    always_ff @(posedge sys_clk) begin
        if (sys_rest || (r_fsm != StMsg)) begin
            r_blink_vis <= 1'b1;
        end else if (w_blink_tc) begin
            r_blink_vis <= ~r_blink_vis;
        end
    end

    assign w_msg_shown = r_blink_vis ? r_msg : FRAME_BLANK;
`else
    assign w_msg_shown = r_msg;
`endif

    // Live frame of the current mode; UART shares the FREE frame generator.
    always_comb begin
        w_live_frame = free_frame;
        case (r_mode)
            MODE_LEARN: w_live_frame = learn_frame;
            MODE_PLAY:  w_live_frame = play_frame;
            default:    w_live_frame = free_frame;
        endcase
    end

    // Next state, message latch, ack and displayed frame; mode change overrides all.
    always_comb begin
        w_fsm_d  = r_fsm;
        w_mode_d = r_mode;
        w_msg_d  = r_msg;
        w_ack_d  = 1'b0;
        case (r_fsm)
            StBanner: w_frame_d = banner_frame(r_mode);
            StLive:   w_frame_d = w_live_frame;
            StMsg:    w_frame_d = w_msg_shown;
            default:  w_frame_d = FRAME_BLANK;
        endcase
        if (w_mode_chg) begin
            w_mode_d = mode_in;
            w_fsm_d  = StBanner;
        end else begin
            case (r_fsm)
                StBanner: if (w_dwell_tc) w_fsm_d = StLive;
                StLive: begin
                    if (msg_req) begin
                        w_msg_d = msg_frame;
                        w_ack_d = 1'b1;
                        w_fsm_d = StMsg;
                    end
                end
                StMsg:    if (w_dwell_tc) w_fsm_d = StLive;
                default:  w_fsm_d = StBanner;
            endcase
        end
    end

    // State and registered outputs; reset discards any latched message.
    always_ff @(posedge sys_clk) begin
        if (sys_rest) begin
            r_fsm       <= StBanner;
            r_mode      <= mode_in;
            r_msg       <= FRAME_BLANK;
            r_frame_out <= FRAME_BLANK;
            r_msg_ack   <= 1'b0;
            r_frame_upd <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_fsm       <= w_fsm_d;
            r_mode      <= w_mode_d;
            r_msg       <= w_msg_d;
            r_frame_out <= w_frame_d;
            r_msg_ack   <= w_ack_d;
            r_frame_upd <= (w_frame_d != r_frame_out);
            r_busy      <= (w_fsm_d != StLive);
        end
    end

    assign frame_out = r_frame_out;
    assign frame_upd = r_frame_upd;
    assign msg_ack   = r_msg_ack;
    assign busy      = r_busy;

endmodule

// File: tb/tb_display_mode_scheduler.sv
// Self-checking bench for display_mode_scheduler against a countdown reference model.
// Honours DISPLAY_MSG_BLINK_EN (message dwell 8 cycles, blink half-period 2).
module tb_display_mode_scheduler;
    import display_mode_scheduler_pkg::*;

    localparam int unsigned BannerCycles = 4;
`ifdef DISPLAY_MSG_BLINK_EN
    localparam int unsigned MsgCycles    = 8;
`else
    localparam int unsigned MsgCycles    = 3;
`endif
    localparam int unsigned BlinkCycles  = 2;

    localparam int PhBanner = 0;
    localparam int PhLive   = 1;
    localparam int PhMsg    = 2;

    logic        sys_clk = 1'b0;
    logic        sys_rest;
    logic [1:0]  mode_in;
    logic [47:0] free_frame, learn_frame, play_frame, msg_frame;
    logic        msg_req;
    logic        msg_ack, frame_upd, busy;
    logic [47:0] frame_out;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state and expected outputs
    int          m_phase, m_left, m_age;
    logic [1:0]  m_mode;
    logic [47:0] m_msg;
    logic [47:0] e_frame;
    logic        e_upd, e_ack, e_busy;

    display_mode_scheduler #(
        .CNT_W         (27),
        .BANNER_CYCLES (BannerCycles),
        .MSG_CYCLES    (MsgCycles),
        .BLINK_CYCLES  (BlinkCycles)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rest    (sys_rest),
        .mode_in     (mode_in),
        .free_frame  (free_frame),
        .learn_frame (learn_frame),
        .play_frame  (play_frame),
        .msg_req     (msg_req),
        .msg_frame   (msg_frame),
        .msg_ack     (msg_ack),
        .frame_out   (frame_out),
        .frame_upd   (frame_upd),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [47:0] rand48();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[47:0];
    endfunction

    function automatic logic [47:0] name_of(logic [1:0] mode);
        logic [47:0] f;
        case (mode)
            2'b00:   f = {CHAR_F, CHAR_R, CHAR_E, CHAR_E, CHAR_BLANK, CHAR_BLANK, CHAR_BLANK,
                          CHAR_BLANK};
            2'b01:   f = {CHAR_L, CHAR_E, CHAR_A, CHAR_R, CHAR_N, CHAR_BLANK, CHAR_BLANK,
                          CHAR_BLANK};
            2'b10:   f = {CHAR_P, CHAR_L, CHAR_A, CHAR_Y, CHAR_BLANK, CHAR_BLANK, CHAR_BLANK,
                          CHAR_BLANK};
            default: f = {CHAR_U, CHAR_A, CHAR_R, CHAR_T, CHAR_BLANK, CHAR_BLANK, CHAR_BLANK,
                          CHAR_BLANK};
        endcase
        return f;
    endfunction

    function automatic logic [47:0] live_of(logic [1:0] mode);
        if (mode == 2'b01) return learn_frame;
        if (mode == 2'b10) return play_frame;
        return free_frame;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        logic [47:0] shown;
        if (sys_rest) begin
            m_mode  = mode_in;
            m_phase = PhBanner;
            m_left  = BannerCycles;
            m_age   = 0;
            m_msg   = 48'hFFFF_FFFF_FFFF;
            e_frame = 48'hFFFF_FFFF_FFFF;
            e_upd   = 1'b0;
            e_ack   = 1'b0;
            e_busy  = 1'b1;
        end else begin
            if (m_phase == PhBanner) shown = name_of(m_mode);
            else if (m_phase == PhLive) shown = live_of(m_mode);
            else begin
                shown = m_msg;
`ifdef DISPLAY_MSG_BLINK_EN
                if (((m_age / BlinkCycles) % 2) == 1) shown = 48'hFFFF_FFFF_FFFF;
`endif
            end
            e_upd   = (shown != e_frame);
            e_frame = shown;
            e_ack   = 1'b0;
            if (mode_in != m_mode) begin
                m_mode  = mode_in;
                m_phase = PhBanner;
                m_left  = BannerCycles;
            end else if (m_phase == PhBanner) begin
                m_left--;
                if (m_left == 0) m_phase = PhLive;
            end else if (m_phase == PhLive) begin
                if (msg_req) begin
                    e_ack   = 1'b1;
                    m_msg   = msg_frame;
                    m_phase = PhMsg;
                    m_left  = MsgCycles;
                    m_age   = 0;
                end
            end else begin
                m_left--;
                m_age++;
                if (m_left == 0) m_phase = PhLive;
            end
            e_busy = (m_phase != PhLive);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        sys_rest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({frame_out, frame_upd, msg_ack, busy} !== {48'hFFFF_FFFF_FFFF, 3'b001}) begin
                n_bad++;
                $display("FAIL reset c%0d: got frame=%h upd=%b ack=%b busy=%b, need %h 0 0 1",
                         i, frame_out, frame_upd, msg_ack, busy, 48'hFFFF_FFFF_FFFF);
            end
        end
    endtask

    task automatic test_banner_live();
        int banner_seen = 0;
        sys_rest = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (frame_out === name_of(2'b00)) banner_seen++;
            n_cmp++;
            if ({frame_out, frame_upd, msg_ack, busy} !== {e_frame, e_upd, e_ack, e_busy}) begin
                n_bad++;
                $display("FAIL banner_live c%0d: got %h %b %b %b, need %h %b %b %b", i,
                         frame_out, frame_upd, msg_ack, busy, e_frame, e_upd, e_ack, e_busy);
            end
            if (i == 6) free_frame = rand48();
        end
        n_cmp++;
        if (banner_seen != BannerCycles) begin
            n_bad++;
            $display("FAIL banner_len: got %0d cycles, need %0d", banner_seen, BannerCycles);
        end
    endtask

    task automatic test_mode_switch();
        play_frame = rand48();
        mode_in    = 2'b10;
        for (int i = 0; i < 24; i++) begin
            tick();
            n_cmp++;
            if ({frame_out, frame_upd, msg_ack, busy} !== {e_frame, e_upd, e_ack, e_busy}) begin
                n_bad++;
                $display("FAIL mode_switch c%0d: got %h %b %b %b, need %h %b %b %b", i,
                         frame_out, frame_upd, msg_ack, busy, e_frame, e_upd, e_ack, e_busy);
            end
            if (i == 7) mode_in = 2'b11;
            if (i == 12) free_frame = rand48();
            if (i == 15) mode_in = 2'b01;
            if (i == 21) learn_frame = rand48();
        end
    endtask

    task automatic test_msg();
        msg_frame = rand48();
        msg_req   = 1'b1;
        for (int i = 0; i < int'(2 * MsgCycles) + 6; i++) begin
            tick();
            n_cmp++;
            if ({frame_out, frame_upd, msg_ack, busy} !== {e_frame, e_upd, e_ack, e_busy}) begin
                n_bad++;
                $display("FAIL msg c%0d: got %h %b %b %b, need %h %b %b %b", i,
                         frame_out, frame_upd, msg_ack, busy, e_frame, e_upd, e_ack, e_busy);
            end
            if (i == 2) learn_frame = rand48();
        end
        msg_req = 1'b0;
        for (int i = 0; i < int'(MsgCycles) + 3; i++) begin
            tick();
            n_cmp++;
            if ({frame_out, frame_upd, msg_ack, busy} !== {e_frame, e_upd, e_ack, e_busy}) begin
                n_bad++;
                $display("FAIL msg_drain c%0d: got %h %b %b %b, need %h %b %b %b", i,
                         frame_out, frame_upd, msg_ack, busy, e_frame, e_upd, e_ack, e_busy);
            end
        end
    endtask

    task automatic test_msg_in_banner();
        mode_in = 2'b00;
        for (int i = 0; i < int'(BannerCycles + MsgCycles) + 5; i++) begin
            tick();
            n_cmp++;
            if ({frame_out, frame_upd, msg_ack, busy} !== {e_frame, e_upd, e_ack, e_busy}) begin
                n_bad++;
                $display("FAIL msg_in_banner c%0d: got %h %b %b %b, need %h %b %b %b", i,
                         frame_out, frame_upd, msg_ack, busy, e_frame, e_upd, e_ack, e_busy);
            end
            if (e_ack) msg_req = 1'b0;
            if (i == 1) begin
                msg_frame = rand48();
                msg_req   = 1'b1;
            end
        end
    endtask

    task automatic test_abort();
        msg_frame = rand48();
        msg_req   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_cmp++;
            if ({frame_out, frame_upd, msg_ack, busy} !== {e_frame, e_upd, e_ack, e_busy}) begin
                n_bad++;
                $display("FAIL abort_msg c%0d: got %h %b %b %b, need %h %b %b %b", i,
                         frame_out, frame_upd, msg_ack, busy, e_frame, e_upd, e_ack, e_busy);
            end
            if (e_ack) msg_req = 1'b0;
            if (i == 1) mode_in = 2'b01;
        end
        // Mode change coinciding with a request: banner wins, no ack on that edge
        mode_in   = 2'b10;
        msg_frame = rand48();
        msg_req   = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i == 0) begin
                n_cmp++;
                if (msg_ack !== 1'b0) begin
                    n_bad++;
                    $display("FAIL abort_coincide_ack: got ack=%b, need 0", msg_ack);
                end
            end
            n_cmp++;
            if ({frame_out, frame_upd, msg_ack, busy} !== {e_frame, e_upd, e_ack, e_busy}) begin
                n_bad++;
                $display("FAIL abort_coincide c%0d: got %h %b %b %b, need %h %b %b %b", i,
                         frame_out, frame_upd, msg_ack, busy, e_frame, e_upd, e_ack, e_busy);
            end
            if (e_ack) msg_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        msg_frame = rand48();
        msg_req   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_cmp++;
            if ({frame_out, frame_upd, msg_ack, busy} !== {e_frame, e_upd, e_ack, e_busy}) begin
                n_bad++;
                $display("FAIL reset_mid c%0d: got %h %b %b %b, need %h %b %b %b", i,
                         frame_out, frame_upd, msg_ack, busy, e_frame, e_upd, e_ack, e_busy);
            end
            if (e_ack) msg_req = 1'b0;
            sys_rest = (i == 1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            tick();
            n_cmp++;
            if ({frame_out, frame_upd, msg_ack, busy} !== {e_frame, e_upd, e_ack, e_busy}) begin
                n_bad++;
                $display("FAIL random c%0d: got %h %b %b %b, need %h %b %b %b", i,
                         frame_out, frame_upd, msg_ack, busy, e_frame, e_upd, e_ack, e_busy);
            end
            if (e_ack) msg_req = 1'b0;
            if ($urandom_range(3, 0) == 0) free_frame  = rand48();
            if ($urandom_range(3, 0) == 0) learn_frame = rand48();
            if ($urandom_range(3, 0) == 0) play_frame  = rand48();
            if ($urandom_range(39, 0) == 0) mode_in = 2'($urandom_range(3, 0));
            if (!msg_req && !e_ack && $urandom_range(9, 0) == 0) begin
                msg_frame = rand48();
                msg_req   = 1'b1;
            end
            sys_rest = ($urandom_range(199, 0) == 0);
        end
        sys_rest = 1'b0;
    endtask

    initial begin
        sys_rest    = 1'b1;
        mode_in     = 2'b00;
        free_frame  = rand48();
        learn_frame = rand48();
        play_frame  = rand48();
        msg_frame   = rand48();
        msg_req     = 1'b0;
        test_reset();
        test_banner_live();
        test_mode_switch();
        test_msg();
        test_msg_in_banner();
        test_abort();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/display_mode_scheduler.md
Name: display_mode_scheduler

Overview:
- Sequences the 8-digit nixie frame path. Selects which mode's 48-bit frame (8 chars x 6-bit codes) reaches the tube driver.
- Inserts a timed mode-name banner on every mode change.
- Overlays one-shot message frames (e.g. study grade) through a req/ack handshake.
- Sits between the mode frame generators and the tube driver, replacing the static state mux.

Parameters:
- CNT_W, 27, width of the dwell timer.
- BANNER_CYCLES, 100_000_000, banner dwell in sys_clk cycles (>=1).
- MSG_CYCLES, 200_000_000, message dwell in cycles (>=1).
- BLINK_CYCLES, 25_000_000, blink half-period (BLINK_EN only, >=1).

Ports:
- sys_clk  in  1  system clock
- sys_rest  in  1  synchronous active-high reset
- mode_in  in  2  00 FREE, 01 LEARN, 10 PLAY, 11 UART
- free_frame  in  48  FREE/UART frame
- learn_frame  in  48  LEARN frame
- play_frame  in  48  PLAY frame (song name)
- msg_req  in  1  message request (level, held until ack)
- msg_frame  in  48  message content, valid while msg_req=1
- msg_ack  out  1  one-cycle accept pulse
- frame_out  out  48  frame to tube driver, [47:42]=leftmost digit
- frame_upd  out  1  one-cycle pulse when frame_out changed
- busy  out  1  high when not in LIVE

Behaviour:
- One clock; reset is synchronous and active-high: sys_clk, sys_rest.
- Reset values:
  - frame_out = FRAME_BLANK (all chars 6'b111111).
  - msg_ack = 0, frame_upd = 0, busy = 1.
  - fsm = BANNER, timer = 0, mode_q <= mode_in.
- FSM states BANNER, LIVE, MSG. Mode change means mode_in != mode_q.
- Mode change has the highest priority in every state:
  - mode_q <= mode_in, fsm <= BANNER, timer <= 0.
  - Any in-progress message is aborted.
  - No ack is issued that cycle.
- BANNER:
  - frame_out <= banner(mode_q): "FrEE", "LEArn", "PLAY", "UArt" left-justified, remaining digits blank.
  - Timer counts up; at timer == BANNER_CYCLES-1, go to LIVE and clear the timer.
- LIVE:
  - frame_out <= selected frame of mode_q. UART uses free_frame.
  - Latency is 1 cycle from a frame input to frame_out.
  - If msg_req=1 and there is no mode change: latch msg_frame, msg_ack=1 for one cycle, go to MSG, clear the timer.
- MSG:
  - frame_out <= latched message; live inputs are ignored.
  - At timer == MSG_CYCLES-1, go to LIVE.
  - msg_req is not sampled in MSG or BANNER. It stays pending and is acked in the first LIVE cycle if still high.
- Handshake rules:
  - The requester drops msg_req within 1 cycle after ack.
  - A req still high on return to LIVE is treated as a new request.
- frame_upd = registered (frame_out_next != frame_out); no pulse when the value is unchanged.
- busy = (fsm != LIVE), registered with the state.
- Timer wraps never; it is cleared on every state entry. Width must hold the max of all dwell parameters minus 1.
- Reset mid-banner or mid-message: immediate return to reset values on the next edge; the latched message is discarded.

Optional Feature:
- Macro: DISPLAY_MSG_BLINK_EN.
- Defined:
  - In MSG, frame_out alternates latched message / FRAME_BLANK every BLINK_CYCLES, starting visible.
  - The blink phase counter is cleared on MSG entry.
  - frame_upd pulses on each toggle.
- Undefined: message is shown steadily and no blink counter is synthesised.

Decomposition:
- Shared package holds:
  - mode codes MODE_FREE/LEARN/PLAY/UART;
  - 6-bit letter codes including CHAR_BLANK = 6'b111111;
  - FRAME_BLANK;
  - the four banner frame constants;
  - the FSM state encodings.
- One sub-module is natural: dwell_timer (clear, enable, terminal-count compare, parameterised width). It is used for the dwell count and, under BLINK_EN, the blink phase.

Test Plan (BANNER_CYCLES=4, MSG_CYCLES=3, BLINK_CYCLES=2):
- Reset with mode_in=00, then release:
  - frame_out=FRAME_BLANK during reset;
  - "FrEE" banner for 4 cycles, busy=1;
  - then free_frame, busy=0, one frame_upd pulse per change.
- In LIVE, switch mode_in 00->10 with play_frame=P:
  - banner "PLAY" from the next cycle for 4 cycles;
  - then frame_out=P; mode 11 shows free_frame after the "UArt" banner.
- In LIVE, msg_req=1, msg_frame=M:
  - msg_ack pulse in the same cycle;
  - frame_out=M for 3 cycles, then back to the live frame.
  - msg_req held high past ack is acked again on LIVE return.
- msg_req raised during banner: no ack until the first LIVE cycle, then normal MSG sequence.
- Mode change in the second MSG cycle, or coinciding with msg_req in LIVE: banner wins, message discarded, no ack.
- DISPLAY_MSG_BLINK_EN defined, MSG_CYCLES=8: frame_out sequence M,M,BLANK,BLANK,M,M,BLANK,BLANK with frame_upd on each toggle. Undefined: M steady for 8 cycles.
